// File: rtl/key_event_arbiter.sv
// Per-player scan-code FIFOs round-robin merged onto one valid/ack event port; push to present is 2 edges.
// Backpressure: evt_valid holds until evt_ack, then one GAP cycle; pushes into a full FIFO are dropped and counted.

module key_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_req,
  input  logic [CODE_W-1:0] push_code,
  input  logic              pop,
  output logic [CODE_W-1:0] head_code,
  output logic              not_empty,
  output logic              full,
  output logic [7:0]        drops
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic [7:0]        drops_q, drops_d;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok = push_req && ((count_q < FULL_CNT) || pop_ok);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    drops_d = drops_q;
    if (push_ok) begin
      mem_d[wr_q] = push_code;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok && (drops_q != 8'hFF)) begin
      drops_d = drops_q + 8'd1;
    end
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      drops_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      full_q  <= full_d;
      drops_q <= drops_d;
    end
  end

  assign head_code = mem_q[rd_q];
  assign not_empty = (count_q != '0);
  assign full      = full_q;
  assign drops     = drops_q;
endmodule

module key_event_arbiter #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p1_ind,
  input  logic [CODE_W-1:0] p1_code,
  input  logic              p2_ind,
  input  logic [CODE_W-1:0] p2_code,
  input  logic              evt_ack,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_player,
  output logic              p1_full,
  output logic              p2_full,
  output logic [7:0]        p1_drops,
  output logic [7:0]        p2_drops
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              evt_player_q, evt_player_d;
  logic              last_grant_q, last_grant_d;

  logic              push1, push2;
  logic              pop1, pop2;
  logic              grant;
  logic [CODE_W-1:0] head1, head2;
  logic              ne1, ne2;

  // prev resets high so a key held through reset is not seen as a new press.
  assign prev_d = {p2_ind, p1_ind};
  assign push1  = p1_ind & ~prev_q[0];
  assign push2  = p2_ind & ~prev_q[1];

  key_event_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_fifo1 (
    .clock     (clock),
    .reset     (reset),
    .push_req  (push1),
    .push_code (p1_code),
    .pop       (pop1),
    .head_code (head1),
    .not_empty (ne1),
    .full      (p1_full),
    .drops     (p1_drops)
  );

  key_event_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_fifo2 (
    .clock     (clock),
    .reset     (reset),
    .push_req  (push2),
    .push_code (p2_code),
    .pop       (pop2),
    .head_code (head2),
    .not_empty (ne2),
    .full      (p2_full),
    .drops     (p2_drops)
  );

  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    evt_player_d = evt_player_q;
    last_grant_d = last_grant_q;
    pop1         = 1'b0;
    pop2         = 1'b0;
    grant        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ne1 || ne2) begin
          // Under contention the player not served last wins.
          grant        = (ne1 && ne2) ? ~last_grant_q : ne2;
          pop1         = ~grant;
          pop2         = grant;
          evt_code_d   = grant ? head2 : head1;
          evt_player_d = grant;
          last_grant_d = grant;
          evt_valid_d  = 1'b1;
          state_d      = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (evt_ack) begin
          evt_valid_d = 1'b0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_q       <= 2'b11;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_player_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_player_q <= evt_player_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_player = evt_player_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: inputs driven and outputs sampled on the falling clock edge.
module tb_key_event_arbiter;
  logic       clock;
  logic       reset;
  logic       p1_ind;
  logic [7:0] p1_code;
  logic       p2_ind;
  logic [7:0] p2_code;
  logic       evt_ack;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_player;
  logic       p1_full;
  logic       p2_full;
  logic [7:0] p1_drops;
  logic [7:0] p2_drops;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  key_event_arbiter #(.DEPTH(4), .CODE_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .p1_ind     (p1_ind),
    .p1_code    (p1_code),
    .p2_ind     (p2_ind),
    .p2_code    (p2_code),
    .evt_ack    (evt_ack),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_player (evt_player),
    .p1_full    (p1_full),
    .p2_full    (p2_full),
    .p1_drops   (p1_drops),
    .p2_drops   (p2_drops)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Raise the indicator for one edge (the enqueue edge), then drop it.
  task automatic press(input logic player, input logic [7:0] code);
    if (!player) begin
      p1_code = code;
      p1_ind  = 1'b1;
    end else begin
      p2_code = code;
      p2_ind  = 1'b1;
    end
    tick();
    if (!player) p1_ind = 1'b0;
    else         p2_ind = 1'b0;
  endtask

  // Wait (bounded) for a presented event, check it, then step past the ack edge.
  task automatic get_evt(input string tag, input logic [7:0] exp_code, input logic exp_pl,
                         inout int t_prev, input bit chk_gap);
    int n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, {31'd0, evt_valid}, 32'd1);
    check_eq({tag, "_code"}, {24'd0, evt_code}, {24'd0, exp_code});
    check_eq({tag, "_player"}, {31'd0, evt_player}, {31'd0, exp_pl});
    if (chk_gap) check_eq({tag, "_spacing"}, cyc - t_prev, 32'd3);
    t_prev = cyc;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes [5];
    logic       pls   [5];
    int         t_last;
    bit         saw;

    t_last  = 0;
    reset   = 1'b1;
    p1_ind  = 1'b1;
    p1_code = 8'h00;
    p2_ind  = 1'b0;
    p2_code = 8'h00;
    evt_ack = 1'b0;

    // Reset with p1 held high: reset values, then no event from the held key.
    tick();
    tick();
    check_eq("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rst_code", {24'd0, evt_code}, 32'd0);
    check_eq("rst_player", {31'd0, evt_player}, 32'd0);
    check_eq("rst_full", {30'd0, p1_full, p2_full}, 32'd0);
    check_eq("rst_drops", {16'd0, p1_drops, p2_drops}, 32'd0);
    reset = 1'b0;
    saw   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (evt_valid) saw = 1'b1;
    end
    check_eq("held_no_evt", {31'd0, saw}, 32'd0);
    check_eq("held_p1_drops", {24'd0, p1_drops}, 32'd0);
    p1_ind = 1'b0;
    tick();

    // Single p1 press with ack held: valid rises 2 edges after the push.
    evt_ack = 1'b1;
    press(1'b0, 8'h33);
    check_eq("lat_after_push", {31'd0, evt_valid}, 32'd0);
    tick();
    check_eq("lat_valid", {31'd0, evt_valid}, 32'd1);
    check_eq("lat_code", {24'd0, evt_code}, 32'h33);
    check_eq("lat_player", {31'd0, evt_player}, 32'd0);
    tick();
    check_eq("ack_fall", {31'd0, evt_valid}, 32'd0);
    evt_ack = 1'b0;
    tick();
    tick();

    // Round-robin order across both players.
    press(1'b0, 8'h33); tick();
    press(1'b0, 8'h3B); tick();
    press(1'b0, 8'h42); tick();
    press(1'b1, 8'h1C); tick();
    press(1'b1, 8'h1B); tick();
    codes[0] = 8'h33; pls[0] = 1'b0;
    codes[1] = 8'h1C; pls[1] = 1'b1;
    codes[2] = 8'h3B; pls[2] = 1'b0;
    codes[3] = 8'h1B; pls[3] = 1'b1;
    codes[4] = 8'h42; pls[4] = 1'b0;
    evt_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_evt($sformatf("rr%0d", i), codes[i], pls[i], t_last, i != 0);
    end
    evt_ack = 1'b0;
    tick();
    tick();

    // Overflow: scheduler busy with a p1 event, six p2 presses -> 4 queued, 2 dropped.
    press(1'b0, 8'h11); tick();
    check_eq("ovf_hold_code", {24'd0, evt_code}, 32'h11);
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 8'hA1 + 8'(i));
      tick();
    end
    check_eq("ovf_full", {31'd0, p2_full}, 32'd1);
    check_eq("ovf_drops", {24'd0, p2_drops}, 32'd2);
    check_eq("ovf_p1_drops", {24'd0, p1_drops}, 32'd0);
    check_eq("ovf_still_valid", {31'd0, evt_valid}, 32'd1);

    // Full FIFO popped and pushed at the same edge: push accepted, no drop.
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    check_eq("sp_gap", {31'd0, evt_valid}, 32'd0);
    tick();
    p2_code = 8'hA7;
    p2_ind  = 1'b1;
    tick();
    p2_ind  = 1'b0;
    check_eq("sp_valid", {31'd0, evt_valid}, 32'd1);
    check_eq("sp_code", {24'd0, evt_code}, 32'hA1);
    check_eq("sp_full", {31'd0, p2_full}, 32'd1);
    check_eq("sp_drops", {24'd0, p2_drops}, 32'd2);
    codes[0] = 8'hA1;
    codes[1] = 8'hA2;
    codes[2] = 8'hA3;
    codes[3] = 8'hA4;
    codes[4] = 8'hA7;
    evt_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_evt($sformatf("drain%0d", i), codes[i], 1'b1, t_last, i != 0);
    end
    check_eq("drain_full", {31'd0, p2_full}, 32'd0);
    evt_ack = 1'b0;
    tick();
    tick();

    // Asynchronous reset while presenting with two entries queued.
    press(1'b0, 8'h21); tick();
    press(1'b0, 8'h22); tick();
    press(1'b1, 8'h23); tick();
    check_eq("mid_pre_code", {24'd0, evt_code}, 32'h21);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_async_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("mid_async_drops", {24'd0, p2_drops}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    saw   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (evt_valid) saw = 1'b1;
    end
    check_eq("mid_no_evt", {31'd0, saw}, 32'd0);
    evt_ack = 1'b1;
    press(1'b1, 8'h44);
    get_evt("post_rst", 8'h44, 1'b1, t_last, 1'b0);
    evt_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
